// File: rtl/bwt_pkg.sv
// rtl/bwt_pkg.sv - shared types and width helpers for the BWT rank engine.
package bwt_pkg;

   typedef enum logic [2:0] {
      IDLE, LOAD, INIT, CMP, COMMIT, SCATTER, OUT, DONE
   } state_e;

   // Key fields are zero-extended to this width; RANK_W must not exceed it.
   localparam int KEY_FW = 16;

   typedef struct packed {
      logic [KEY_FW-1:0] hi;
      logic [KEY_FW-1:0] lo;
   } key_t;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

   function automatic int rank_w(input int cw, input int n);
      return (cw > $clog2(n)) ? cw : $clog2(n);
   endfunction

endpackage

// File: rtl/bwt_key_cmp.sv
// rtl/bwt_key_cmp.sv - LANES parallel rotation-key comparators producing a
// less-than count and an equal-to-another-row flag per cycle.
module bwt_key_cmp
   import bwt_pkg::*;
#(
   parameter int LANES = 4,
   parameter int IDX_W = 5,
   parameter int CNT_W = $clog2(LANES + 1)
) (
   input  key_t                   key_i,
   input  key_t [LANES-1:0]       key_j,
   input  logic [IDX_W-1:0]       i_idx,
   input  logic [IDX_W-1:0]       j_base,
   input  logic                   tie_break,
   output logic [CNT_W-1:0]       lt_cnt,
   output logic                   eq_other
);

   always_comb begin
      lt_cnt   = '0;
      eq_other = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         // Final phase: equal keys are ordered by start index to force a permutation.
         if ((key_j[l] < key_i) ||
             (tie_break && (key_j[l] == key_i) && ((int'(j_base) + l) < int'(i_idx))))
            lt_cnt = lt_cnt + CNT_W'(1);
         if ((key_j[l] == key_i) && ((int'(j_base) + l) != int'(i_idx)))
            eq_other = 1'b1;
      end
   end

endmodule

// File: rtl/bwt_rank_engine.sv
// rtl/bwt_rank_engine.sv - cyclic BWT engine ranking rotations by prefix doubling.
// BWT_EARLY_EXIT_EN: skip remaining phases once ranks are unique; adds phases_used.
module bwt_rank_engine
   import bwt_pkg::*;
#(
   parameter int STR_LEN = 32,
   parameter int CHAR_W  = 8,
   parameter int LANES   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CHAR_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CHAR_W-1:0]          out_data,
   output logic                       out_last,
   output logic [$clog2(STR_LEN)-1:0] primary_idx,
   output logic                       busy,
   output logic                       done
`ifdef BWT_EARLY_EXIT_EN
   ,
   output logic [$clog2(STR_LEN)-1:0] phases_used
`endif
);

   localparam int IDX_W  = idx_w(STR_LEN);
   localparam int RANK_W = rank_w(CHAR_W, STR_LEN);
   localparam int P      = IDX_W;
   localparam int CNT_W  = $clog2(LANES + 1);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(STR_LEN - 1);
   localparam logic [IDX_W-1:0] J_LAST = IDX_W'(STR_LEN - LANES);
   localparam logic [IDX_W-1:0] P_LAST = IDX_W'(P - 1);

   state_e state, state_nx;

   logic [CHAR_W-1:0] sym   [STR_LEN];
   logic [CHAR_W-1:0] bwt   [STR_LEN];
   logic [RANK_W-1:0] rank  [STR_LEN];
   logic [RANK_W-1:0] nrank [STR_LEN];

   logic [IDX_W-1:0] cnt, j_base, p, acc;
   logic             tie, finish_ph;
   logic [IDX_W:0]   sum;
   logic [CNT_W-1:0] lt_cnt;
   logic             eq_other;
   key_t             key_i;
   key_t [LANES-1:0] key_j;

   function automatic logic [IDX_W-1:0] partner(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] sh);
      logic [IDX_W:0] s;
      s = {1'b0, a} + ((IDX_W+1)'(1) << sh);
      if (s >= (IDX_W+1)'(STR_LEN))
         s = s - (IDX_W+1)'(STR_LEN);
      return s[IDX_W-1:0];
   endfunction

   always_comb begin
      key_i.hi = KEY_FW'(rank[cnt]);
      key_i.lo = KEY_FW'(rank[partner(cnt, p)]);
      for (int l = 0; l < LANES; l++) begin
         key_j[l].hi = KEY_FW'(rank[j_base + IDX_W'(l)]);
         key_j[l].lo = KEY_FW'(rank[partner(j_base + IDX_W'(l), p)]);
      end
   end

   bwt_key_cmp #(.LANES(LANES), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_cmp (
      .key_i    (key_i),
      .key_j    (key_j),
      .i_idx    (cnt),
      .j_base   (j_base),
      .tie_break(p == P_LAST),
      .lt_cnt   (lt_cnt),
      .eq_other (eq_other)
   );

   assign sum = {1'b0, acc} + (IDX_W+1)'(lt_cnt);

`ifdef BWT_EARLY_EXIT_EN
   assign finish_ph = (p == P_LAST) || !tie;
`else
   logic tie_unused;
   assign tie_unused = tie;
   assign finish_ph  = (p == P_LAST);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    if (in_valid && cnt == LAST) state_nx = INIT;
         INIT:    state_nx = CMP;
         CMP:     if (j_base == J_LAST && cnt == LAST) state_nx = COMMIT;
         COMMIT:  state_nx = finish_ph ? SCATTER : CMP;
         SCATTER: if (cnt == LAST) state_nx = OUT;
         OUT:     if (out_ready && cnt == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STR_LEN; i++) begin
            sym[i]   <= '0;
            bwt[i]   <= '0;
            rank[i]  <= '0;
            nrank[i] <= '0;
         end
         cnt         <= '0;
         j_base      <= '0;
         p           <= '0;
         acc         <= '0;
         tie         <= 1'b0;
         primary_idx <= '0;
`ifdef BWT_EARLY_EXIT_EN
         phases_used <= '0;
`endif
      end else begin
         case (state)
            IDLE: cnt <= '0;
            LOAD: if (in_valid) begin
               sym[cnt] <= in_data;
               cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            INIT: begin
               for (int i = 0; i < STR_LEN; i++)
                  rank[i] <= RANK_W'(sym[i]);
               p      <= '0;
               j_base <= '0;
               acc    <= '0;
               tie    <= 1'b0;
               cnt    <= '0;
            end
            CMP: begin
               if (eq_other) tie <= 1'b1;
               if (j_base == J_LAST) begin
                  nrank[cnt] <= RANK_W'(sum);
                  acc        <= '0;
                  j_base     <= '0;
                  cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
               end else begin
                  acc    <= sum[IDX_W-1:0];
                  j_base <= j_base + IDX_W'(LANES);
               end
            end
            COMMIT: begin
               for (int i = 0; i < STR_LEN; i++)
                  rank[i] <= nrank[i];
               p   <= p + 1'b1;
               tie <= 1'b0;
`ifdef BWT_EARLY_EXIT_EN
               phases_used <= p + 1'b1;
`endif
            end
            SCATTER: begin
               // Row rank[i] ends with the symbol preceding rotation i.
               bwt[rank[cnt][IDX_W-1:0]] <= sym[(cnt == '0) ? LAST : cnt - 1'b1];
               primary_idx <= rank[0][IDX_W-1:0];
               cnt         <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            OUT: if (out_ready) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == LOAD);
   assign out_valid = (state == OUT);
   assign out_data  = bwt[cnt];
   assign out_last  = out_valid && (cnt == LAST);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule
